// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan path.
package seg_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_OFF = 7'b0;

  // One digit's worth of buffered display state.
  typedef struct packed {
    seg_t seg;  // already-encoded segment pattern
    logic dp;   // decimal point (carries the product sign)
    logic en;   // digit lit for its drive window
  } digit_t;

  localparam digit_t DIGIT_DARK = '{seg: SEG_OFF, dp: 1'b0, en: 1'b0};

endpackage

// File: rtl/slot_timer.sv
// Scan timebase: a prescale counter splitting each digit slot into a blank
// window and a drive window, plus the digit index that walks the frame.
// The registers hold the position of the cycle that the next clock edge
// starts, so consumers can register outputs that line up with that cycle.
module slot_timer #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int BLANK      = 16,
  parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             blank_o,      // upcoming cycle is in the blank window
  output logic [IDX_W-1:0] idx_o,        // digit owning the upcoming cycle
  output logic             frame_last_o  // current cycle is the last of a frame
);

  localparam int K_W = $clog2(PRESCALE);

  logic [K_W-1:0]   k_q, k_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             started_q;

  // Advance the slot counter; roll the digit index at the end of each slot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    k_d   = k_q + 1'b1;
    idx_d = idx_q;
    if (k_q == K_W'(PRESCALE - 1)) begin
      k_d   = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Counter state; started_q masks the reset position, which is not a frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      k_q       <= '0;
      idx_q     <= '0;
      started_q <= 1'b0;
    end else begin
      k_q       <= k_d;
      idx_q     <= idx_d;
      started_q <= 1'b1;
    end
  end

  assign blank_o      = (k_q < K_W'(BLANK));
  assign idx_o        = idx_q;
  assign frame_last_o = started_q && (k_q == '0) && (idx_q == '0);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes NUM_DIGITS pre-encoded seven-segment digits onto one
// shared segment bus with per-digit active-low anodes and a blanking gap at
// the start of every slot. Input data is double-buffered and only swapped in
// at a frame boundary, so a frame is never torn.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int BLANK      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [SEG_W*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  output logic [NUM_DIGITS-1:0]       an_n,
  output logic [SEG_W-1:0]            seg,
  output logic                        dp,
  output logic                        upd_pending,
  output logic                        frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  digit_t [NUM_DIGITS-1:0] in_buf;
  digit_t [NUM_DIGITS-1:0] pend_q, pend_d;
  digit_t [NUM_DIGITS-1:0] act_q, act_d;
  logic                    upd_q, upd_d;

  logic                    blank;
  logic [IDX_W-1:0]        idx;
  logic                    frame_last;

  digit_t                  cur;
  logic [NUM_DIGITS-1:0]   an_n_d, an_n_q;
  seg_t                    seg_d, seg_q;
  logic                    dp_d, dp_q;
  logic                    frame_done_q;

  slot_timer #(
    .NUM_DIGITS(NUM_DIGITS),
    .PRESCALE  (PRESCALE),
    .BLANK     (BLANK),
    .IDX_W     (IDX_W)
  ) u_slot_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .blank_o     (blank),
    .idx_o       (idx),
    .frame_last_o(frame_last)
  );

  // Repack the flat input ports into per-digit records.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      in_buf[i].seg = seg_in[SEG_W*i +: SEG_W];
      in_buf[i].dp  = dp_in[i];
      in_buf[i].en  = digit_en[i];
    end
  end

  // Load into the pending buffer; at a frame end promote pending (or bypass a
  // same-cycle load straight) into the active buffer.
  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    upd_d  = upd_q;
    if (frame_last) begin
      if (load) begin
        act_d = in_buf;
      end else if (upd_q) begin
        act_d = pend_q;
      end
      upd_d = 1'b0;
    end else if (load) begin
      pend_d = in_buf;
      upd_d  = 1'b1;
    end
  end

  // Decode the upcoming cycle from the post-transfer active buffer, so fresh
  // data lands in digit 0 of the new frame regardless of the blank length.
  always_comb begin
    cur    = act_d[idx];
    an_n_d = '1;
    seg_d  = SEG_OFF;
    dp_d   = 1'b0;
    if (!blank && cur.en) begin
      an_n_d[idx] = 1'b0;
      seg_d       = cur.seg;
      dp_d        = cur.dp;
    end
  end

  // Buffers, handshake flag and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the digit buffers are reset on purpose: cleared enables are what keep the display dark after reset.
      pend_q       <= {NUM_DIGITS{DIGIT_DARK}};
      act_q        <= {NUM_DIGITS{DIGIT_DARK}};
      upd_q        <= 1'b0;
      an_n_q       <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      act_q        <= act_d;
      upd_q        <= upd_d;
      an_n_q       <= an_n_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_last;
    end
  end

  assign an_n        = an_n_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign upd_pending = upd_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with NUM_DIGITS=4, PRESCALE=8, BLANK=2.
// cyc N is the clock period that begins at the N-th rising edge after reset
// release; outputs are sampled on the falling edge inside that period.
module tb_seg_scan_mux;

  localparam int ND = 4;
  localparam int PS = 8;
  localparam int BL = 2;
  localparam int FRAME = ND * PS;

  localparam logic [27:0] PAT_1 = {7'b0010010, 7'b1011101, 7'b0111010, 7'b1110111};
  localparam logic [27:0] PAT_A = {7'b1111111, 7'b0000001, 7'b1000000, 7'b0101010};
  localparam logic [27:0] PAT_B = {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011};
  localparam logic [27:0] PAT_C = {7'b1011011, 7'b1011111, 7'b1110000, 7'b0111111};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [27:0] seg_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  an_n;
  logic [6:0]  seg;
  logic        dp;
  logic        upd_pending;
  logic        frame_done;

  int cyc = -1;
  int n_checks = 0;
  int n_fail = 0;

  seg_scan_mux #(
    .NUM_DIGITS(ND),
    .PRESCALE  (PS),
    .BLANK     (BL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .seg_in     (seg_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .an_n       (an_n),
    .seg        (seg),
    .dp         (dp),
    .upd_pending(upd_pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cyc %0d): got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Advance into the next period and park on its falling edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Reset for two cycles with load held high (must be ignored), then release
  // on a falling edge so the next rising edge is cyc 0.
  task automatic do_reset();
    rst_n = 1'b0;
    load  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst an_n", 32'(an_n), 32'hF);
    check("rst seg", 32'(seg), 32'h0);
    check("rst upd", 32'(upd_pending), 32'h0);
    check("rst frame_done", 32'(frame_done), 32'h0);
    load  = 1'b0;
    rst_n = 1'b1;
    cyc   = -1;
  endtask

  // Expected scan outputs for the current cyc given the active digit table.
  task automatic check_disp(input string tag, input logic [27:0] pat,
                            input logic [3:0] dpv, input logic [3:0] env);
    int         k;
    int         d;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    k     = cyc % PS;
    d     = (cyc / PS) % ND;
    e_an  = 4'hF;
    e_seg = '0;
    e_dp  = 1'b0;
    if (k >= BL && env[d]) begin
      e_an[d] = 1'b0;
      e_seg   = pat[7*d +: 7];
      e_dp    = dpv[d];
    end
    check({tag, " an_n"}, 32'(an_n), 32'(e_an));
    check({tag, " seg"}, 32'(seg), 32'(e_seg));
    check({tag, " dp"}, 32'(dp), 32'(e_dp));
    check({tag, " frame_done"}, 32'(frame_done), 32'(cyc > 0 && (cyc % FRAME) == 0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: idle after reset, dark display, frame_done only at 32 and 64.
    do_reset();
    while (cyc < 64) begin
      step();
      check_disp("t1", '0, '0, '0);
      check("t1 upd", 32'(upd_pending), 32'h0);
    end

    // 2: single load at cyc 3, visible from the next frame.
    do_reset();
    seg_in   = PAT_1;
    dp_in    = 4'b0101;
    digit_en = 4'hF;
    while (cyc < 63) begin
      load = (cyc == 3);
      step();
      check("t2 upd", 32'(upd_pending), 32'(cyc >= 4 && cyc <= 31));
      if (cyc >= 32) check_disp("t2", PAT_1, 4'b0101, 4'hF);
      else           check_disp("t2", '0, '0, '0);
      if (cyc == 34) begin
        check("t2 an_n@34", 32'(an_n), 32'b1110);
        check("t2 seg@34", 32'(seg), 32'b1110111);
        check("t2 dp@34", 32'(dp), 32'h1);
      end
      if (cyc == 40) check("t2 gap an_n@40", 32'(an_n), 32'b1111);
      if (cyc == 42) begin
        check("t2 an_n@42", 32'(an_n), 32'b1101);
        check("t2 seg@42", 32'(seg), 32'b0111010);
        check("t2 dp@42", 32'(dp), 32'h0);
      end
    end
    load = 1'b0;

    // 3: load A then B before the transfer; only B is ever shown.
    do_reset();
    dp_in    = 4'b1010;
    digit_en = 4'hF;
    while (cyc < 63) begin
      load = 1'b0;
      if (cyc == 5) begin
        seg_in = PAT_A;
        load   = 1'b1;
      end else if (cyc == 20) begin
        seg_in = PAT_B;
        load   = 1'b1;
      end else if (cyc > 20) begin
        seg_in = PAT_C;
      end
      step();
      check("t3 upd", 32'(upd_pending), 32'(cyc >= 6 && cyc <= 31));
      if (cyc >= 32) check_disp("t3", PAT_B, 4'b1010, 4'hF);
      else           check_disp("t3", '0, '0, '0);
    end
    load = 1'b0;

    // 4: load on the last cycle of the frame bypasses the pending buffer.
    do_reset();
    seg_in   = PAT_C;
    dp_in    = 4'b0011;
    digit_en = 4'hF;
    while (cyc < 63) begin
      load = (cyc == 31);
      step();
      check("t4 upd", 32'(upd_pending), 32'h0);
      if (cyc >= 32) check_disp("t4", PAT_C, 4'b0011, 4'hF);
      else           check_disp("t4", '0, '0, '0);
    end
    load = 1'b0;

    // 5: only digit 2 enabled; other slots stay dark, frame timing unchanged.
    do_reset();
    seg_in   = PAT_1;
    dp_in    = 4'b1111;
    digit_en = 4'b0100;
    while (cyc < 64) begin
      load = (cyc == 3);
      step();
      if (cyc >= 32) check_disp("t5", PAT_1, 4'b1111, 4'b0100);
      else           check_disp("t5", '0, '0, '0);
      if (cyc == 42) check("t5 an_n@42", 32'(an_n), 32'b1111);
      if (cyc == 49) check("t5 an_n@49", 32'(an_n), 32'b1111);
      if (cyc == 50) check("t5 an_n@50", 32'(an_n), 32'b1011);
      if (cyc == 55) check("t5 an_n@55", 32'(an_n), 32'b1011);
      if (cyc == 56) check("t5 an_n@56", 32'(an_n), 32'b1111);
    end
    load = 1'b0;

    // 6: reset mid-drive with an update pending; dark at once and afterwards.
    do_reset();
    seg_in   = PAT_1;
    dp_in    = 4'b0101;
    digit_en = 4'hF;
    while (cyc < 37) begin
      load = 1'b0;
      if (cyc == 3) load = 1'b1;
      if (cyc == 34) begin
        seg_in = PAT_B;
        load   = 1'b1;
      end
      step();
    end
    load = 1'b0;
    check("t6 pre an_n", 32'(an_n), 32'b1110);
    check("t6 pre upd", 32'(upd_pending), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6 async an_n", 32'(an_n), 32'hF);
    check("t6 async seg", 32'(seg), 32'h0);
    check("t6 async dp", 32'(dp), 32'h0);
    check("t6 async upd", 32'(upd_pending), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = -1;
    while (cyc < 64) begin
      step();
      check_disp("t6", '0, '0, '0);
      check("t6 upd", 32'(upd_pending), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
